// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Receives a framed byte stream (SYNC_BYTE, LEN_LO, LEN_HI, N*4 data bytes),
// packs the bytes little-endian into 32-bit words and writes them to IMEM from
// word address 0 upward. The core is held while a frame is in progress and
// DONE pulses once the frame has been fully written.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect one trailing
// byte equal to the XOR of all data bytes; a mismatch sets ERROR with DONE.
module imem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDRESS,
  output logic [31:0]           WR_DATA,
  output logic                  CPU_HOLD,
  output logic                  DONE,
  output logic                  ERROR
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd5;
`endif
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]            state;
  logic [7:0]            len_lo;
  logic [15:0]           words_left;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic        accept;
  logic [15:0] frame_len;

  // Frame lengths beyond the memory depth are rejected before any write.
  function automatic logic too_long(input logic [15:0] n);
    return 32'(n) > (32'd1 << ADDR_WIDTH);
  endfunction

  // Handshake and status outputs decode directly from the current state.
  always_comb begin
    RX_READY   = (state != S_WRITE) && (state != S_DONE);
    WR_EN      = (state == S_WRITE);
    DONE       = (state == S_DONE);
    CPU_HOLD   = (state != S_IDLE);
    WR_ADDRESS = addr_q;
    WR_DATA    = data_q;
    ERROR      = error_q;
  end

  assign accept    = RX_VALID && RX_READY;
  assign frame_len = {RX_DATA, len_lo};

  // Frame parser: walks header, packs data bytes, issues one write per word.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      len_lo     <= 8'd0;
      words_left <= 16'd0;
      byte_cnt   <= 2'd0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && (RX_DATA == SYNC_BYTE)) begin
            error_q <= 1'b0;
            state   <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= RX_DATA;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            if (frame_len == 16'd0) begin
              state <= S_DONE;
            end else if (too_long(frame_len)) begin
              error_q <= 1'b1;
              state   <= S_IDLE;
            end else begin
              words_left <= frame_len;
              addr_q     <= '0;
              byte_cnt   <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum       <= 8'd0;
`endif
              state      <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            data_q[8*byte_cnt +: 8] <= RX_DATA;
            byte_cnt                <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum                    <= csum ^ RX_DATA;
`endif
            if (byte_cnt == 2'd3) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          words_left <= words_left - 16'd1;
          if (words_left == 16'd1) begin
            // Address stays on the last written word once the frame ends.
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= S_CHK;
`else
            state <= S_DONE;
`endif
          end else begin
            addr_q <= addr_q + 1'b1;
            state  <= S_DATA;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            if (RX_DATA != csum) error_q <= 1'b1;
            state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
